// File: rtl/ladybird_lsu_arbiter.sv
// Round-robin arbiter sharing one ladybird_lsu port between N_REQ requesters.
// Responses are steered back to their issuer through an in-order tag FIFO.
module ladybird_lsu_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned XLEN      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*XLEN-1:0] req_addr,
    input  logic [N_REQ*XLEN-1:0] req_data,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [N_REQ*3-1:0]    req_funct,
    input  logic [N_REQ-1:0]      req_fence,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]       rsp_data,
    output logic                  lsu_valid,
    input  logic                  lsu_ready,
    output logic [XLEN-1:0]       lsu_addr,
    output logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_we,
    output logic [2:0]            lsu_funct,
    output logic                  lsu_fence,
    input  logic                  lsu_rvalid,
    output logic                  lsu_rready,
    input  logic [XLEN-1:0]       lsu_rdata,
    output logic                  err_orphan
);

    localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTST);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTST - 1);
    localparam logic [IdW-1:0]  IdLast  = IdW'(N_REQ - 1);

    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [IdW-1:0]  lock_id_q, lock_id_d;
    logic [IdW-1:0]  tag_q [MAX_OUTST];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            err_orphan_q, err_orphan_d;

    logic [IdW-1:0]  grant;
    logic [IdW-1:0]  head;
    logic            has_outst;
    logic            issue_ok;
    logic            fence_wait;
    logic            accept;
    logic            pop;
    logic            orphan;

    // Grant: locked requester wins, otherwise first valid at or after rr_ptr.
    always_comb begin
        logic        found;
        int unsigned idx;
        grant = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            grant = lock_id_q;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                idx = (32'(rr_ptr_q) + i) % N_REQ;
                if (!found && req_valid[IdW'(idx)]) begin
                    found = 1'b1;
                    grant = IdW'(idx);
                end
            end
        end
    end

    assign has_outst  = (count_q != '0);
    assign head       = tag_q[rd_ptr_q];
    // A pop in the same cycle does not free a slot; fences also need a full drain.
    assign issue_ok   = (count_q < CntMax) && (!req_fence[grant] || !has_outst);
    assign fence_wait = req_valid[grant] && req_fence[grant] && !issue_ok;

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = !rst && lsu_ready && issue_ok;
        rsp_valid        = '0;
        rsp_valid[head]  = !rst && lsu_rvalid && has_outst;
    end

    assign lsu_valid  = !rst && req_valid[grant] && issue_ok;
    assign lsu_addr   = req_addr[32'(grant) * XLEN +: XLEN];
    assign lsu_data   = req_data[32'(grant) * XLEN +: XLEN];
    assign lsu_we     = req_we[grant];
    assign lsu_funct  = req_funct[32'(grant) * 3 +: 3];
    assign lsu_fence  = req_fence[grant];
    // Orphan responses are drained without being presented to any requester.
    assign lsu_rready = !rst && (has_outst ? rsp_ready[head] : lsu_rvalid);
    assign rsp_data   = lsu_rdata;
    assign err_orphan = err_orphan_q;

    assign accept = lsu_valid && lsu_ready;
    assign pop    = lsu_rvalid && lsu_rready && has_outst;
    assign orphan = !rst && lsu_rvalid && !has_outst;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_orphan_d = err_orphan_q || orphan;

        if (accept) begin
            lock_d   = 1'b0;
            rr_ptr_d = (grant == IdLast) ? '0 : grant + 1'b1;
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end else if ((lsu_valid && !lsu_ready) || fence_wait) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
            if (accept) begin
                tag_q[wr_ptr_q] <= grant;
            end
        end
    end

endmodule

// File: tb/tb_ladybird_lsu_arbiter.sv
// Directed self-checking bench for ladybird_lsu_arbiter (N_REQ=2, MAX_OUTST=2, XLEN=32).
module tb_ladybird_lsu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, req_fence, rsp_valid, rsp_ready;
    logic [63:0] req_addr, req_data;
    logic [5:0]  req_funct;
    logic [31:0] rsp_data, lsu_addr, lsu_data, lsu_rdata;
    logic        lsu_valid, lsu_ready, lsu_we, lsu_fence, lsu_rvalid, lsu_rready, err_orphan;
    logic [2:0]  lsu_funct;

    int n_checks = 0;
    int n_errors = 0;

    ladybird_lsu_arbiter #(
        .N_REQ     (2),
        .MAX_OUTST (2),
        .XLEN      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_we     (req_we),
        .req_funct  (req_funct),
        .req_fence  (req_fence),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .lsu_we     (lsu_we),
        .lsu_funct  (lsu_funct),
        .lsu_fence  (lsu_fence),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rready (lsu_rready),
        .lsu_rdata  (lsu_rdata),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid  = '0;
        req_we     = '0;
        req_fence  = '0;
        req_addr   = '0;
        req_data   = '0;
        req_funct  = '0;
        rsp_ready  = '0;
        lsu_ready  = 1'b0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = '0;
    endtask

    initial begin
        idle();
        // Reset cycle: drive everything active, outputs must still be quiet.
        rst        = 1'b1;
        req_valid  = 2'b11;
        lsu_ready  = 1'b1;
        lsu_rvalid = 1'b1;
        rsp_ready  = 2'b11;
        #1;
        check_eq("rst_lsu_valid", 32'(lsu_valid), 0);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_lsu_rready", 32'(lsu_rready), 0);
        cyc();
        cyc();
        rst = 1'b0;
        idle();
        #1;
        check_eq("rst_err_orphan", 32'(err_orphan), 0);
        cyc();

        // T1: round-robin with immediate responses.
        for (int k = 0; k < 4; k++) begin
            req_valid  = 2'b11;
            lsu_ready  = 1'b1;
            lsu_rvalid = (k > 0);
            rsp_ready  = 2'b11;
            #1;
            check_eq("t1_req_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) check_eq("t1_rsp_valid", 32'(rsp_valid), (k % 2 == 1) ? 32'h1 : 32'h2);
            cyc();
        end
        req_valid = 2'b00;
        #1;
        check_eq("t1_last_rsp", 32'(rsp_valid), 32'h2);
        cyc();
        idle();

        // T2: backpressure lock on req0 while req1 waits.
        req_valid = 2'b01;
        req_addr  = {32'h200, 32'h100};
        for (int k = 0; k < 3; k++) begin
            if (k > 0) req_valid = 2'b11;
            #1;
            check_eq("t2_lsu_valid", 32'(lsu_valid), 1);
            check_eq("t2_lsu_addr", lsu_addr, 32'h100);
            check_eq("t2_req_ready", 32'(req_ready), 0);
            cyc();
        end
        lsu_ready = 1'b1;
        #1;
        check_eq("t2_accept0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b10;
        #1;
        check_eq("t2_addr1", lsu_addr, 32'h200);
        check_eq("t2_accept1", 32'(req_ready), 32'h2);
        cyc();
        idle();
        lsu_rvalid = 1'b1;
        rsp_ready  = 2'b11;
        #1;
        check_eq("t2_rsp0", 32'(rsp_valid), 32'h1);
        cyc();
        #1;
        check_eq("t2_rsp1", 32'(rsp_valid), 32'h2);
        cyc();
        idle();

        // T3: FIFO full holds the third load until after the first pop.
        req_valid = 2'b10;
        lsu_ready = 1'b1;
        req_addr  = {32'h40, 32'h0};
        #1;
        check_eq("t3_issue0", 32'(req_ready), 32'h2);
        cyc();
        #1;
        check_eq("t3_issue1", 32'(req_ready), 32'h2);
        cyc();
        #1;
        check_eq("t3_full_valid", 32'(lsu_valid), 0);
        check_eq("t3_full_ready", 32'(req_ready), 0);
        cyc();
        lsu_rvalid = 1'b1;
        rsp_ready  = 2'b10;
        #1;
        check_eq("t3_pop_rsp", 32'(rsp_valid), 32'h2);
        check_eq("t3_pop_no_free", 32'(lsu_valid), 0);
        cyc();
        lsu_rvalid = 1'b0;
        #1;
        check_eq("t3_issue2", 32'(lsu_valid), 1);
        check_eq("t3_issue2_rdy", 32'(req_ready), 32'h2);
        cyc();
        req_valid  = 2'b00;
        lsu_rvalid = 1'b1;
        cyc();
        cyc();
        idle();

        // T4: in-order response routing.
        req_valid = 2'b11;
        lsu_ready = 1'b1;
        req_addr  = {32'h11, 32'h10};
        req_funct = {3'b000, 3'b010};
        #1;
        check_eq("t4_addr0", lsu_addr, 32'h10);
        check_eq("t4_funct0", 32'(lsu_funct), 32'h2);
        cyc();
        req_valid = 2'b10;
        #1;
        check_eq("t4_addr1", lsu_addr, 32'h11);
        check_eq("t4_funct1", 32'(lsu_funct), 32'h0);
        cyc();
        req_valid  = 2'b00;
        lsu_rvalid = 1'b1;
        rsp_ready  = 2'b11;
        lsu_rdata  = 32'hDEADBEEF;
        #1;
        check_eq("t4_rsp0_valid", 32'(rsp_valid), 32'h1);
        check_eq("t4_rsp0_data", rsp_data, 32'hDEADBEEF);
        cyc();
        lsu_rdata = 32'hFFFFFFBE;
        #1;
        check_eq("t4_rsp1_valid", 32'(rsp_valid), 32'h2);
        check_eq("t4_rsp1_data", rsp_data, 32'hFFFFFFBE);
        cyc();
        idle();

        // T5: fence from req1 waits for drain while req0 is blocked.
        req_valid = 2'b01;
        lsu_ready = 1'b1;
        cyc();
        cyc();
        req_valid = 2'b11;
        req_fence = 2'b10;
        #1;
        check_eq("t5_drain_valid", 32'(lsu_valid), 0);
        check_eq("t5_drain_ready", 32'(req_ready), 0);
        cyc();
        lsu_rvalid = 1'b1;
        rsp_ready  = 2'b11;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("t5_drain_rsp", 32'(rsp_valid), 32'h1);
            check_eq("t5_blocked", 32'(lsu_valid), 0);
            cyc();
        end
        lsu_rvalid = 1'b0;
        #1;
        check_eq("t5_fence_valid", 32'(lsu_valid), 1);
        check_eq("t5_fence_flag", 32'(lsu_fence), 1);
        check_eq("t5_fence_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid  = 2'b00;
        req_fence  = 2'b00;
        lsu_rvalid = 1'b1;
        #1;
        check_eq("t5_fence_rsp", 32'(rsp_valid), 32'h2);
        cyc();
        idle();

        // T6: orphan response, then reset with one outstanding.
        lsu_rvalid = 1'b1;
        #1;
        check_eq("t6_orphan_rready", 32'(lsu_rready), 1);
        check_eq("t6_orphan_rsp", 32'(rsp_valid), 0);
        cyc();
        lsu_rvalid = 1'b0;
        req_valid  = 2'b01;
        lsu_ready  = 1'b1;
        #1;
        check_eq("t6_err_orphan", 32'(err_orphan), 1);
        cyc();
        idle();
        rst = 1'b1;
        #1;
        check_eq("t6_rst_rready", 32'(lsu_rready), 0);
        cyc();
        rst = 1'b0;
        #1;
        check_eq("t6_post_err", 32'(err_orphan), 0);
        check_eq("t6_post_valid", 32'(lsu_valid), 0);
        check_eq("t6_post_rdy", 32'(req_ready), 0);
        lsu_rvalid = 1'b1;
        rsp_ready  = 2'b11;
        #1;
        check_eq("t6_tag_flushed", 32'(rsp_valid), 0);
        check_eq("t6_drain_orphan", 32'(lsu_rready), 1);
        cyc();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
